// File: rtl/keccak_absorb.sv
// -----------------------------------------------------------------------------
// keccak_absorb
//   Sponge absorb front end for Keccak-f[1600]. Message words are XORed into
//   the rate lanes of a 1600-bit state. Multi-rate padding (DSEP ... 0x80) is
//   applied on the final word. An external permutation core is requested
//   once per full block, or once more when the padding spills into an extra
//   block.
//
// Parameters
//   RATE_LANES : 64-bit rate lanes per block (9..21; 21 = SHAKE128)
//   DSEP       : domain-separation / pad-start byte (8'h1F SHAKE, 8'h06 SHA3)
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   clear        : synchronous restart (zero state, back to absorbing)
//   in_valid     : in_data/in_last/in_bytes are valid
//   in_ready     : word accepted when in_valid && in_ready
//   in_data      : message word, byte k at bits 8k..8k+7 (bit j at 8k+j)
//   in_last      : final message word
//   in_bytes     : valid bytes in the final word (0..8, low bytes first)
//   perm_start   : one-cycle request to permute state_out
//   perm_done    : one-cycle pulse, state_in holds the permuted state
//   state_in     : permuted state, lane i at bits 64i..64i+63
//   state_out    : registered state, lane i = 5y+x, bit z at 64i+z
//   absorb_done  : high while absorption is complete
// -----------------------------------------------------------------------------
module keccak_absorb #(
   parameter int         RATE_LANES = 21,
   parameter logic [7:0] DSEP       = 8'h1F
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [0:63]   in_data,
   input  logic          in_last,
   input  logic [3:0]    in_bytes,
   output logic          perm_start,
   input  logic          perm_done,
   input  logic [0:1599] state_in,
   output logic [0:1599] state_out,
   output logic          absorb_done
);

   localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

   typedef enum logic [1:0] {ST_ABSORB, ST_PERM, ST_PAD, ST_DONE} state_t;

   state_t        r_fsm;
   state_t        w_fsm_next;

   // Lanes are kept little-endian internally: r_lane[i][z] is bit z of lane i,
   // so byte k of a lane is simply r_lane[i][8k+7:8k].
   logic [63:0]   r_lane [25];
   logic [63:0]   w_in_lane [25];
   logic [1599:0] w_xor_flat;
   logic [63:0]   w_word;
   logic [63:0]   w_word_masked;
   logic [4:0]    r_lane_cnt;
   logic          r_final;
   logic          r_pad_pending;
   logic          r_perm_start;

   logic          w_hs;
   logic          w_full;
   logic          w_spill;
   logic          w_dsep_en;
   logic [4:0]    w_dsep_lane;
   logic [2:0]    w_dsep_byte;
   logic          w_pad_en;

   assign in_ready    = rst_n && (r_fsm == ST_ABSORB) && !clear;
   assign w_hs        = in_valid && in_ready;
   assign w_full      = (in_bytes >= 4'd8);
   // A full final word in the last rate lane leaves no room for the padding:
   // the pad moves to a separate block built in PAD.
   assign w_spill     = w_hs && in_last && w_full && (r_lane_cnt == LAST_LANE);
   assign perm_start  = r_perm_start;
   assign absorb_done = (r_fsm == ST_DONE);

   // Bit-order translation between the ascending port vectors and the lanes.
   always_comb begin
      for (int i = 0; i < 25; i++) begin
         for (int z = 0; z < 64; z++) begin
            w_in_lane[i][z]   = state_in[64*i+z];
            state_out[64*i+z] = r_lane[i][z];
         end
      end
      for (int z = 0; z < 64; z++) begin
         w_word[z] = in_data[z];
      end
   end

   // Where the DSEP byte and the closing 0x80 land this cycle.
   always_comb begin
      w_dsep_en   = 1'b0;
      w_dsep_lane = r_lane_cnt;
      w_dsep_byte = in_bytes[2:0];
      w_pad_en    = 1'b0;
      if (r_fsm == ST_PAD) begin
         w_dsep_en   = 1'b1;
         w_dsep_lane = 5'd0;
         w_dsep_byte = 3'd0;
         w_pad_en    = 1'b1;
      end else if (w_hs && in_last && !w_spill) begin
         w_dsep_en = 1'b1;
         w_pad_en  = 1'b1;
         if (w_full) begin
            w_dsep_lane = r_lane_cnt + 5'd1;
            w_dsep_byte = 3'd0;
         end
      end
   end

   genvar gi, gb;
   generate
      for (gb = 0; gb < 8; gb++) begin : g_mask
         assign w_word_masked[8*gb +: 8] =
            (!in_last || (4'(gb) < in_bytes)) ? w_word[8*gb +: 8] : 8'h00;
      end

      // Per-byte XOR contribution: message byte, DSEP byte and pad-end byte
      // are independent terms, so coinciding DSEP and 0x80 combine naturally.
      for (gi = 0; gi < 25; gi++) begin : g_lane
         for (gb = 0; gb < 8; gb++) begin : g_byte
            logic [7:0] w_msg_b;
            logic [7:0] w_dsep_b;
            logic [7:0] w_pad_b;
            assign w_msg_b  = (w_hs && (r_lane_cnt == 5'(gi))) ?
                              w_word_masked[8*gb +: 8] : 8'h00;
            assign w_dsep_b = (w_dsep_en && (w_dsep_lane == 5'(gi)) &&
                               (w_dsep_byte == 3'(gb))) ? DSEP : 8'h00;
            assign w_pad_b  = (w_pad_en && (gi == RATE_LANES - 1) && (gb == 7)) ?
                              8'h80 : 8'h00;
            assign w_xor_flat[64*gi + 8*gb +: 8] = w_msg_b ^ w_dsep_b ^ w_pad_b;
         end
      end
   endgenerate

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm <= ST_ABSORB;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   // FSM next state.
   always_comb begin
      w_fsm_next = r_fsm;
      if (clear) begin
         w_fsm_next = ST_ABSORB;
      end else begin
         case (r_fsm)
            ST_ABSORB: if (w_hs && (in_last || (r_lane_cnt == LAST_LANE)))
                          w_fsm_next = ST_PERM;
            ST_PERM:   if (perm_done) begin
                          if (r_final)            w_fsm_next = ST_DONE;
                          else if (r_pad_pending) w_fsm_next = ST_PAD;
                          else                    w_fsm_next = ST_ABSORB;
                       end
            ST_PAD:    w_fsm_next = ST_PERM;
            ST_DONE:   w_fsm_next = ST_DONE;
            default:   w_fsm_next = ST_ABSORB;
         endcase
      end
   end

   // Datapath: state lanes, lane counter, padding flags, perm request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 25; i++) r_lane[i] <= '0;
         r_lane_cnt    <= '0;
         r_final       <= 1'b0;
         r_pad_pending <= 1'b0;
         r_perm_start  <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < 25; i++) r_lane[i] <= '0;
         r_lane_cnt    <= '0;
         r_final       <= 1'b0;
         r_pad_pending <= 1'b0;
         r_perm_start  <= 1'b0;
      end else begin
         // Pulse on every entry into PERM, i.e. its first cycle only.
         r_perm_start <= (r_fsm != ST_PERM) && (w_fsm_next == ST_PERM);
         case (r_fsm)
            ST_ABSORB: if (w_hs) begin
               for (int i = 0; i < 25; i++) r_lane[i] <= r_lane[i] ^ w_xor_flat[64*i +: 64];
               r_lane_cnt <= r_lane_cnt + 5'd1;
               if (in_last) begin
                  r_final       <= !w_spill;
                  r_pad_pending <= w_spill;
               end
            end
            ST_PERM: if (perm_done) begin
               for (int i = 0; i < 25; i++) r_lane[i] <= w_in_lane[i];
               r_lane_cnt <= '0;
            end
            ST_PAD: begin
               for (int i = 0; i < 25; i++) r_lane[i] <= r_lane[i] ^ w_xor_flat[64*i +: 64];
               r_pad_pending <= 1'b0;
               r_final       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_absorb.sv
`timescale 1ns/1ps
module tb_keccak_absorb;
   localparam int R = 21;
   localparam logic [63:0] PAD_END = 64'h8000_0000_0000_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          perm_done = 1'b0;
   logic [0:63]   in_data = '0;
   logic [3:0]    in_bytes = '0;
   logic [0:1599] state_in = '0;
   logic          in_ready;
   logic          perm_start;
   logic          absorb_done;
   logic [0:1599] state_out;

   int n_cmp = 0;
   int n_fail = 0;
   int n_starts = 0;

   keccak_absorb #(.RATE_LANES(R), .DSEP(8'h1F)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_bytes(in_bytes),
      .perm_start(perm_start), .perm_done(perm_done),
      .state_in(state_in), .state_out(state_out), .absorb_done(absorb_done)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (perm_start) n_starts++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // XOR a lane value (bit z = lane bit z) into an expected state.
   function automatic logic [0:1599] xl(input logic [0:1599] s, input int lane,
                                        input logic [63:0] v);
      for (int z = 0; z < 64; z++) s[64*lane+z] = s[64*lane+z] ^ v[z];
      return s;
   endfunction

   function automatic logic [63:0] gl(input logic [0:1599] s, input int lane);
      logic [63:0] v;
      for (int z = 0; z < 64; z++) v[z] = s[64*lane+z];
      return v;
   endfunction

   function automatic int first_diff(input logic [0:1599] a, input logic [0:1599] b);
      for (int l = 0; l < 25; l++) if (gl(a, l) !== gl(b, l)) return l;
      return 0;
   endfunction

   // Message word i: every byte equal to i+1.
   function automatic logic [63:0] wv(input int i);
      logic [7:0] b;
      b = 8'(i + 1);
      return {8{b}};
   endfunction

   // Arbitrary stand-in for a permuted state.
   function automatic logic [0:1599] pat(input logic [31:0] seed);
      logic [0:1599] s;
      s = '0;
      for (int i = 0; i < 25; i++) s = xl(s, i, {seed + 32'(i), ~seed ^ 32'(i * 3)});
      return s;
   endfunction

   task automatic send(input logic [63:0] v, input logic last, input logic [3:0] nb,
                       output bit ok);
      @(posedge clk); #1;
      for (int z = 0; z < 64; z++) in_data[z] = v[z];
      in_last = last;
      in_bytes = nb;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      in_bytes = '0;
   endtask

   task automatic perm(input logic [0:1599] ps, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (perm_start) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      state_in = ps;
      perm_done = 1'b1;
      @(posedge clk); #1;
      perm_done = 1'b0;
   endtask

   task automatic do_clear();
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (state_out !== '0) begin n_fail++;
         $display("FAIL reset_state: lane %0d got %h want 0", first_diff(state_out, '0), gl(state_out, first_diff(state_out, '0))); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
      n_cmp++; if (absorb_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", absorb_done); end
      n_cmp++; if (perm_start !== 1'b0) begin n_fail++; $display("FAIL reset_pstart: got %b want 0", perm_start); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", in_ready); end
      $display("reset: state zero, in_ready low in reset and high after release");
   endtask

   task automatic test_empty();
      logic [0:1599] exp;
      logic [0:1599] p;
      bit ok;
      int base;
      base = n_starts;
      exp = xl('0, 0, 64'h1F);
      exp = xl(exp, 20, PAD_END);
      p = pat(32'hC0FF_EE00);
      send(64'h0, 1'b1, 4'd0, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL empty_hs: got no handshake want handshake"); end
      @(negedge clk);
      n_cmp++; if (perm_start !== 1'b1) begin n_fail++; $display("FAIL empty_pstart: got %b want 1", perm_start); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL empty_ready: got %b want 0", in_ready); end
      n_cmp++; if (state_out !== exp) begin n_fail++;
         $display("FAIL empty_state: lane %0d got %h want %h", first_diff(state_out, exp), gl(state_out, first_diff(state_out, exp)), gl(exp, first_diff(state_out, exp))); end
      perm(p, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL empty_perm_wait: got timeout want perm_start"); end
      repeat (3) @(negedge clk);
      n_cmp++; if (absorb_done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b want 1", absorb_done); end
      n_cmp++; if (state_out !== p) begin n_fail++;
         $display("FAIL empty_perm_state: lane %0d got %h want %h", first_diff(state_out, p), gl(state_out, first_diff(state_out, p)), gl(p, first_diff(state_out, p))); end
      n_cmp++; if (n_starts - base !== 1) begin n_fail++; $display("FAIL empty_nstart: got %0d want 1", n_starts - base); end
      do_clear();
      @(negedge clk);
      n_cmp++; if (state_out !== '0 || absorb_done !== 1'b0) begin n_fail++;
         $display("FAIL empty_clear: got done=%b lane0=%h want done=0 zero", absorb_done, gl(state_out, 0)); end
      $display("empty message: lane0=%h lane20=%h then permuted, absorb_done set", gl(exp, 0), gl(exp, 20));
   endtask

   task automatic test_dsep_positions();
      logic [0:1599] exp;
      bit ok;
      // 3 valid bytes: DSEP right after them in lane 0.
      exp = xl('0, 0, 64'h0000_0000_1FFF_FFFF);
      exp = xl(exp, 20, PAD_END);
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd3, ok);
      @(negedge clk);
      n_cmp++; if (state_out !== exp) begin n_fail++;
         $display("FAIL partial3_state: lane %0d got %h want %h", first_diff(state_out, exp), gl(state_out, first_diff(state_out, exp)), gl(exp, first_diff(state_out, exp))); end
      perm(pat(32'h1), ok);
      do_clear();
      $display("partial 3 bytes: lane0=%h", gl(exp, 0));
      // Full final word in lane 1: DSEP goes to lane 2 byte 0; in_bytes ignored when not last.
      exp = xl('0, 0, 64'h1122_3344_5566_7788);
      exp = xl(exp, 1, 64'h99AA_BBCC_DDEE_FF00);
      exp = xl(exp, 2, 64'h1F);
      exp = xl(exp, 20, PAD_END);
      send(64'h1122_3344_5566_7788, 1'b0, 4'd3, ok);
      send(64'h99AA_BBCC_DDEE_FF00, 1'b1, 4'd8, ok);
      @(negedge clk);
      n_cmp++; if (state_out !== exp) begin n_fail++;
         $display("FAIL full_last_state: lane %0d got %h want %h", first_diff(state_out, exp), gl(state_out, first_diff(state_out, exp)), gl(exp, first_diff(state_out, exp))); end
      perm(pat(32'h2), ok);
      do_clear();
      $display("full last word in lane 1: lane2=%h", gl(exp, 2));
   endtask

   task automatic test_lane20_b7();
      logic [0:1599] exp;
      logic [0:1599] p;
      bit ok;
      int base;
      base = n_starts;
      exp = '0;
      for (int i = 0; i < 20; i++) begin
         send(wv(i), 1'b0, 4'd0, ok);
         exp = xl(exp, i, wv(i));
      end
      n_cmp++; if (n_starts - base !== 0) begin n_fail++; $display("FAIL b7_early_start: got %0d want 0", n_starts - base); end
      exp = xl(exp, 20, 64'h9F15_1515_1515_1515);
      send(wv(20), 1'b1, 4'd7, ok);
      @(negedge clk);
      n_cmp++; if (state_out !== exp) begin n_fail++;
         $display("FAIL b7_state: lane %0d got %h want %h", first_diff(state_out, exp), gl(state_out, first_diff(state_out, exp)), gl(exp, first_diff(state_out, exp))); end
      p = pat(32'hA5A5_0007);
      perm(p, ok);
      @(negedge clk);
      n_cmp++; if (absorb_done !== 1'b1 || n_starts - base !== 1) begin n_fail++;
         $display("FAIL b7_single_perm: got done=%b starts=%0d want done=1 starts=1", absorb_done, n_starts - base); end
      do_clear();
      $display("in_bytes=7 on lane 20: lane20=%h, one permutation", gl(exp, 20));
   endtask

   task automatic test_spill();
      logic [0:1599] exp;
      logic [0:1599] p1;
      logic [0:1599] p2;
      bit ok;
      int base;
      base = n_starts;
      exp = '0;
      for (int i = 0; i < 21; i++) begin
         send(wv(i), (i == 20), (i == 20) ? 4'd8 : 4'd0, ok);
         exp = xl(exp, i, wv(i));
      end
      @(negedge clk);
      n_cmp++; if (state_out !== exp) begin n_fail++;
         $display("FAIL spill_block1: lane %0d got %h want %h", first_diff(state_out, exp), gl(state_out, first_diff(state_out, exp)), gl(exp, first_diff(state_out, exp))); end
      p1 = pat(32'h5EED_0001);
      p2 = pat(32'h5EED_0002);
      perm(p1, ok);
      @(negedge clk);
      n_cmp++; if (absorb_done !== 1'b0 || in_ready !== 1'b0) begin n_fail++;
         $display("FAIL spill_pad_cycle: got done=%b ready=%b want 0 0", absorb_done, in_ready); end
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (perm_start) ok = 1'b1;
      end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL spill_pstart2: got timeout want second perm_start"); end
      exp = xl(p1, 0, 64'h1F);
      exp = xl(exp, 20, PAD_END);
      n_cmp++; if (state_out !== exp) begin n_fail++;
         $display("FAIL spill_pad_state: lane %0d got %h want %h", first_diff(state_out, exp), gl(state_out, first_diff(state_out, exp)), gl(exp, first_diff(state_out, exp))); end
      perm(p2, ok);
      @(negedge clk);
      n_cmp++; if (absorb_done !== 1'b1 || state_out !== p2 || n_starts - base !== 2) begin n_fail++;
         $display("FAIL spill_final: got done=%b starts=%0d lane0=%h want done=1 starts=2 lane0=%h", absorb_done, n_starts - base, gl(state_out, 0), gl(p2, 0)); end
      do_clear();
      $display("21 full words, last in_bytes=8: pad block lane0=%h lane20=%h, two permutations", gl(exp, 0), gl(exp, 20));
   endtask

   task automatic test_stall();
      logic [0:1599] exp;
      logic [0:1599] p;
      logic [63:0] w;
      bit ok;
      bit ready_seen;
      int base;
      base = n_starts;
      w = 64'hDEAD_BEEF_0BAD_F00D;
      p = pat(32'h0000_5747);
      for (int i = 0; i < 21; i++) send(wv(i), 1'b0, 4'd0, ok);
      for (int z = 0; z < 64; z++) in_data[z] = w[z];
      in_valid = 1'b1;
      ready_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (in_ready !== 1'b0) ready_seen = 1'b1;
      end
      n_cmp++; if (ready_seen) begin n_fail++; $display("FAIL stall_ready: got in_ready=1 in PERM want 0"); end
      @(posedge clk); #1;
      state_in = p;
      perm_done = 1'b1;
      @(posedge clk); #1;
      perm_done = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      exp = xl(p, 0, w);
      n_cmp++; if (state_out !== exp) begin n_fail++;
         $display("FAIL stall_word: lane %0d got %h want %h", first_diff(state_out, exp), gl(state_out, first_diff(state_out, exp)), gl(exp, first_diff(state_out, exp))); end
      n_cmp++; if (n_starts - base !== 1) begin n_fail++; $display("FAIL stall_nstart: got %0d want 1", n_starts - base); end
      do_clear();
      $display("stall through PERM: held word absorbed into lane 0 = %h", gl(exp, 0));
   endtask

   task automatic test_clear_perm();
      bit ok;
      int base;
      base = n_starts;
      send(64'h0, 1'b1, 4'd0, ok);
      @(negedge clk);
      @(posedge clk); #1;
      clear = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready_low: got %b want 0", in_ready); end
      @(posedge clk); #1;
      clear = 1'b0;
      @(negedge clk);
      n_cmp++; if (state_out !== '0 || in_ready !== 1'b1) begin n_fail++;
         $display("FAIL clear_state: got ready=%b lane0=%h want ready=1 zero", in_ready, gl(state_out, 0)); end
      @(posedge clk); #1;
      state_in = pat(32'hBAD0_0000);
      perm_done = 1'b1;
      @(posedge clk); #1;
      perm_done = 1'b0;
      @(negedge clk);
      n_cmp++; if (state_out !== '0 || absorb_done !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
         $display("FAIL clear_stale_done: got done=%b ready=%b lane0=%h want 0 1 zero", absorb_done, in_ready, gl(state_out, 0)); end
      n_cmp++; if (n_starts - base !== 1) begin n_fail++; $display("FAIL clear_nstart: got %0d want 1", n_starts - base); end
      $display("clear in PERM: state zeroed, stale perm_done ignored");
   endtask

   task automatic test_reset_mid();
      logic [0:1599] exp;
      logic [63:0] w;
      bit ok;
      w = 64'h0123_4567_89AB_CDEF;
      for (int i = 0; i < 5; i++) send(wv(i), 1'b0, 4'd0, ok);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (state_out !== '0 || in_ready !== 1'b0) begin n_fail++;
         $display("FAIL rst_async: got ready=%b lane0=%h want ready=0 zero", in_ready, gl(state_out, 0)); end
      @(negedge clk);
      rst_n = 1'b1;
      send(w, 1'b0, 4'd0, ok);
      @(negedge clk);
      exp = xl('0, 0, w);
      n_cmp++; if (state_out !== exp) begin n_fail++;
         $display("FAIL rst_lane0: lane %0d got %h want %h", first_diff(state_out, exp), gl(state_out, first_diff(state_out, exp)), gl(exp, first_diff(state_out, exp))); end
      send(64'h0, 1'b1, 4'd0, ok);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      state_in = pat(32'h0000_0D1E);
      perm_done = 1'b1;
      @(posedge clk); #1;
      perm_done = 1'b0;
      @(negedge clk);
      n_cmp++; if (state_out !== '0 || absorb_done !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
         $display("FAIL rst_mid_perm: got done=%b ready=%b lane0=%h want 0 1 zero", absorb_done, in_ready, gl(state_out, 0)); end
      $display("reset mid-absorb: state zeroed at once, next word in lane 0; mid-perm reset discards perm_done");
   endtask

   initial begin
      test_reset();
      test_empty();
      test_dsep_positions();
      test_lane20_b7();
      test_spill();
      test_stall();
      test_clear_perm();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
